// File: rtl/gpio_input_debounce.sv
// Input-pin front end: two-flop synchroniser, per-bit debounce counter,
// and sticky rise/fall event flags that are ORed into a single interrupt.
module gpio_input_debounce #(
    parameter int               WIDTH           = 8,
    parameter int               DEBOUNCE_CYCLES = 1024,
    parameter logic [WIDTH-1:0] RESET_LEVEL     = '0
) (
    input  logic             clk,
    input  logic             power_on_reset,
    input  logic [WIDTH-1:0] pins_in,
    input  logic [WIDTH-1:0] rise_en,
    input  logic [WIDTH-1:0] fall_en,
    input  logic             clear_valid,
    input  logic [WIDTH-1:0] clear_mask,
    output logic [WIDTH-1:0] stable,
    output logic [WIDTH-1:0] edge_pending,
    output logic             irq
);

    localparam int            CW      = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];
    logic [WIDTH-1:0] rise_evt, fall_evt, clr_sel;

    // A level is accepted only after sync2 has disagreed with stable for N edges in a row.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    // Set has priority over a simultaneous clear on the same bit.
    always_comb begin
        rise_evt = stable_d & ~stable_q & rise_en;
        fall_evt = ~stable_d & stable_q & fall_en;
        clr_sel  = {WIDTH{clear_valid}} & clear_mask;
        pend_d   = (pend_q & ~clr_sel) | rise_evt | fall_evt;
    end

    always_ff @(posedge clk or posedge power_on_reset) begin
        if (power_on_reset) begin
            sync1_q  <= RESET_LEVEL;
            sync2_q  <= RESET_LEVEL;
            stable_q <= RESET_LEVEL;
            pend_q   <= '0;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q  <= pins_in;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            pend_q   <= pend_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable       = stable_q;
    assign edge_pending = pend_q;
    assign irq          = |pend_q;

endmodule

// File: tb/tb_gpio_input_debounce.sv
// Bench for gpio_input_debounce: directed pin sequences, with every output change
// matched against a queue of expected {cycle, stable, edge_pending, irq} events.
module tb_gpio_input_debounce;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rst16 = 1'b1;
    logic [7:0]  pins = '0, rise_en = '0, fall_en = '0, clear_mask = '0;
    logic        clear_valid = 1'b0;
    logic [7:0]  stable, pend;
    logic        irq;
    logic [7:0]  pins16 = '0, rise16 = '0;
    logic [7:0]  stable16, pend16;
    logic        irq16;

    logic [31:0] cyc = '0;
    int          checks = 0;
    int          errors = 0;

    logic [48:0] exp_q[$];
    logic [48:0] exp16_q[$];
    logic [16:0] last4 = '0;
    logic [16:0] last16 = '0;

    gpio_input_debounce #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .RESET_LEVEL(8'h00)) dut (
        .clk(clk), .power_on_reset(rst), .pins_in(pins),
        .rise_en(rise_en), .fall_en(fall_en),
        .clear_valid(clear_valid), .clear_mask(clear_mask),
        .stable(stable), .edge_pending(pend), .irq(irq)
    );

    gpio_input_debounce #(.WIDTH(8), .DEBOUNCE_CYCLES(16), .RESET_LEVEL(8'h00)) dut16 (
        .clk(clk), .power_on_reset(rst16), .pins_in(pins16),
        .rise_en(rise16), .fall_en(8'h00),
        .clear_valid(1'b0), .clear_mask(8'h00),
        .stable(stable16), .edge_pending(pend16), .irq(irq16)
    );

    // clock/reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 32'd1;

    function automatic logic [48:0] mk(input logic [31:0] c, input logic [7:0] s,
                                       input logic [7:0] p, input logic i);
        return {c, s, p, i};
    endfunction

    task automatic check_val(input string name, input logic [48:0] got, input logic [48:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got cyc=%0d stable=%h pend=%h irq=%b want cyc=%0d stable=%h pend=%h irq=%b",
                     name, got[48:17], got[16:9], got[8:1], got[0],
                     want[48:17], want[16:9], want[8:1], want[0]);
        end
    endtask

    // scoreboard monitors: an output change consumes one expected event
    always @(negedge clk) begin
        logic [48:0] obs;
        obs = {cyc, stable, pend, irq};
        if (obs[16:0] !== last4) begin
            last4 = obs[16:0];
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut4_unexpected_change got cyc=%0d stable=%h pend=%h irq=%b",
                         cyc, stable, pend, irq);
            end else begin
                check_val("dut4_event", obs, exp_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        logic [48:0] obs;
        obs = {cyc, stable16, pend16, irq16};
        if (obs[16:0] !== last16) begin
            last16 = obs[16:0];
            if (exp16_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut16_unexpected_change got cyc=%0d stable=%h pend=%h irq=%b",
                         cyc, stable16, pend16, irq16);
            end else begin
                check_val("dut16_event", obs, exp16_q.pop_front());
            end
        end
    end

    // driver tasks
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic direct(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    initial begin
        logic [31:0] t;
        logic [5:0]  bounce;
        bounce = 6'b101101;  // applied LSB first: 1,0,1,1,0,1

        tick(3);
        rst   = 1'b0;
        rst16 = 1'b0;
        tick(3);

        // single rise on bit 0: update lands N+2 = 6 edges after the pin changes
        rise_en = 8'h01;
        pins    = 8'h01;
        t = cyc;
        exp_q.push_back(mk(t + 6, 8'h01, 8'h01, 1'b1));
        tick(10);

        // 3-cycle glitch on bit 1 is filtered
        rise_en = 8'hFF;
        fall_en = 8'hFF;
        pins    = 8'h03;
        tick(3);
        pins    = 8'h01;
        tick(10);
        direct("glitch_stable", stable, 8'h01);
        direct("glitch_pending", pend, 8'h01);

        // bouncing bit 2 yields exactly one rise, timed from the start of the final hold
        rise_en = 8'h04;
        fall_en = 8'h04;
        t = cyc;
        exp_q.push_back(mk(t + 11, 8'h05, 8'h05, 1'b1));
        for (int k = 0; k < 6; k++) begin
            pins[2] = bounce[k];
            tick(1);
        end
        tick(10);

        // bit 0 falls with fall_en[0]=0: stable changes, pending does not
        rise_en = 8'h01;
        fall_en = 8'h04;
        pins[0] = 1'b0;
        t = cyc;
        exp_q.push_back(mk(t + 6, 8'h04, 8'h05, 1'b1));
        tick(10);

        // bit 0 rises on the same edge that clears 8'h05: set wins on bit 0
        pins[0] = 1'b1;
        t = cyc;
        exp_q.push_back(mk(t + 6, 8'h05, 8'h01, 1'b1));
        tick(5);
        clear_valid = 1'b1;
        clear_mask  = 8'h05;
        tick(1);
        clear_valid = 1'b0;
        clear_mask  = 8'hFF;
        tick(3);

        // last pending bit cleared: irq drops on that edge
        clear_valid = 1'b1;
        clear_mask  = 8'h01;
        t = cyc;
        exp_q.push_back(mk(t + 1, 8'h05, 8'h00, 1'b0));
        tick(1);
        clear_valid = 1'b0;
        clear_mask  = 8'h00;
        tick(3);

        // asynchronous reset mid-cycle, then no spurious events after release
        rise_en = 8'hFF;
        fall_en = 8'hFF;
        @(posedge clk);
        #2;
        t = cyc;
        pins = 8'h00;
        rst  = 1'b1;
        exp_q.push_back(mk(t, 8'h00, 8'h00, 1'b0));
        #1;
        direct("async_rst_stable", stable, 8'h00);
        direct("async_rst_pending", pend, 8'h00);
        direct("async_rst_irq", {7'd0, irq}, 8'h00);
        tick(2);
        rst = 1'b0;
        tick(12);

        // N=16: reset during a 10-cycle hold restarts the full N+2 latency
        rise16 = 8'hFF;
        pins16 = 8'h08;
        tick(10);
        rst16 = 1'b1;
        tick(1);
        rst16 = 1'b0;
        t = cyc;
        exp16_q.push_back(mk(t + 18, 8'h08, 8'h08, 1'b1));
        tick(25);

        direct("dut4_queue_drained", 8'(exp_q.size()), 8'h00);
        direct("dut16_queue_drained", 8'(exp16_q.size()), 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
